// File: rtl/insn_fetch_queue.sv
// Instruction prefetch queue: issues ROM fetches, buffers returned words with
// their PC in a small FIFO and hands them to the executor over valid/ready.
module insn_fetch_queue #(
   parameter int                  PC_WIDTH   = 16,
   parameter int                  INSN_BYTES = 5,
   parameter int                  INSN_WIDTH = INSN_BYTES * 8,
   parameter int                  DEPTH      = 4,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                         clk,
   input  logic                         reset_n,
   output logic [PC_WIDTH-1:0]          iaddr,
   input  logic [INSN_WIDTH-1:0]        idata,
   input  logic                         redirect,
   input  logic [PC_WIDTH-1:0]          redirect_pc,
   output logic [INSN_WIDTH-1:0]        insn,
   output logic [PC_WIDTH-1:0]          insn_pc,
   output logic                         insn_valid,
   input  logic                         insn_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int                  CNT_W   = $clog2(DEPTH + 1);
   localparam int                  PTR_W   = $clog2(DEPTH);
   localparam logic [PC_WIDTH-1:0] PC_INC  = PC_WIDTH'(INSN_BYTES);
   localparam logic [CNT_W:0]      DEPTH_C = (CNT_W + 1)'(DEPTH);

   logic [PC_WIDTH-1:0]   fetch_pc_reg;
   logic                  pending_reg;
   logic [PC_WIDTH-1:0]   pending_pc_reg;
   logic [CNT_W-1:0]      count_reg;
   logic [CNT_W-1:0]      count_next;
   logic [PTR_W-1:0]      head_reg;
   logic [PTR_W-1:0]      tail_reg;
   logic [CNT_W:0]        occupancy;
   logic                  issue;
   logic                  push;
   logic                  pop;

   logic [INSN_WIDTH-1:0] entry_insn [DEPTH];
   logic [PC_WIDTH-1:0]   entry_pc   [DEPTH];

   // The in-flight fetch already owns a slot, so it is counted as occupancy;
   // a same-cycle pop is deliberately not credited back.
   assign occupancy = {1'b0, count_reg} + (CNT_W + 1)'(pending_reg);
   assign issue     = !redirect && (occupancy < DEPTH_C);
   assign push      = pending_reg && !redirect;
   assign pop       = (count_reg != '0) && insn_ready && !redirect;

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc_reg   <= RESET_PC;
         pending_reg    <= 1'b0;
         pending_pc_reg <= '0;
         count_reg      <= '0;
         head_reg       <= '0;
         tail_reg       <= '0;
      end else if (redirect) begin
         fetch_pc_reg <= redirect_pc;
         pending_reg  <= 1'b0;
         count_reg    <= '0;
         head_reg     <= '0;
         tail_reg     <= '0;
      end else begin
         pending_reg <= issue;
         if (issue) begin
            pending_pc_reg <= fetch_pc_reg;
            fetch_pc_reg   <= fetch_pc_reg + PC_INC;
         end
         if (push) begin
            tail_reg <= tail_reg + PTR_W'(1);
         end
         if (pop) begin
            head_reg <= head_reg + PTR_W'(1);
         end
         count_reg <= count_next;
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [INSN_WIDTH-1:0] insn_reg;
         logic [PC_WIDTH-1:0]   pc_reg;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               insn_reg <= '0;
               pc_reg   <= '0;
            end else if (push && (tail_reg == PTR_W'(gi))) begin
               insn_reg <= idata;
               pc_reg   <= pending_pc_reg;
            end
         end

         assign entry_insn[gi] = insn_reg;
         assign entry_pc[gi]   = pc_reg;
      end
   endgenerate

   assign iaddr      = fetch_pc_reg;
   assign insn       = entry_insn[head_reg];
   assign insn_pc    = entry_pc[head_reg];
   assign insn_valid = (count_reg != '0);
   assign count      = count_reg;

endmodule

// File: tb/tb_insn_fetch_queue.sv
// Bench for insn_fetch_queue: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based model.
module tb_insn_fetch_queue;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic [15:0] iaddr, iaddr2;
   logic [39:0] idata, idata2;
   logic        redirect;
   logic [15:0] rpc;
   logic [39:0] insn, insn2;
   logic [15:0] insn_pc, insn_pc2;
   logic        insn_valid, insn_valid2;
   logic        ready;
   logic [2:0]  count, count2;
   logic        redirect2 = 1'b0;
   logic [15:0] rpc2 = 16'h0;
   logic        ready2 = 1'b1;

   insn_fetch_queue dut (
      .clk(clk), .reset_n(reset_n), .iaddr(iaddr), .idata(idata),
      .redirect(redirect), .redirect_pc(rpc), .insn(insn), .insn_pc(insn_pc),
      .insn_valid(insn_valid), .insn_ready(ready), .count(count)
   );

   insn_fetch_queue #(.RESET_PC(16'hFFFD)) dut_wrap (
      .clk(clk), .reset_n(reset_n), .iaddr(iaddr2), .idata(idata2),
      .redirect(redirect2), .redirect_pc(rpc2), .insn(insn2), .insn_pc(insn_pc2),
      .insn_valid(insn_valid2), .insn_ready(ready2), .count(count2)
   );

   function automatic logic [39:0] rom_f(input logic [15:0] a);
      return {8'h5A, a, ~a};
   endfunction

   // Synchronous ROM: word for the address sampled at the previous edge
   always @(posedge clk) begin
      idata  <= rom_f(iaddr);
      idata2 <= rom_f(iaddr2);
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: FIFO of PCs, one in-flight fetch slot, next fetch PC
   logic [15:0] mq[$];
   bit          m_pend;
   logic [15:0] m_ppc, m_fpc;

   task automatic model_reset();
      mq.delete();
      m_pend = 0;
      m_ppc  = 16'h0;
      m_fpc  = 16'h0;
   endtask

   task automatic model_edge();
      bit issue;
      if (redirect) begin
         $display("redirect to %h (dropping %0d queued)", rpc, mq.size());
         mq.delete();
         m_pend = 0;
         m_fpc  = rpc;
      end else begin
         issue = (mq.size() + int'(m_pend)) < 4;
         if (mq.size() > 0 && ready) begin
            $display("pop pc=%h", mq[0]);
            void'(mq.pop_front());
         end
         if (m_pend) mq.push_back(m_ppc);
         if (issue) begin
            m_ppc = m_fpc;
            m_fpc = m_fpc + 16'd5;
         end
         m_pend = issue;
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic model_check(input string tag);
      chk({tag, ".valid"}, insn_valid, mq.size() != 0);
      chk({tag, ".count"}, count, mq.size());
      chk({tag, ".iaddr"}, iaddr, m_fpc);
      if (mq.size() != 0) begin
         chk({tag, ".insn_pc"}, insn_pc, mq[0]);
         chk({tag, ".insn"}, insn, rom_f(mq[0]));
      end
   endtask

   typedef struct {
      logic        rdy;
      logic        redir;
      logic [15:0] rpc;
      logic        exp_valid;
      int          exp_count;
      logic [15:0] exp_pc;
      logic [15:0] exp_iaddr;
   } vec_t;

   vec_t        vecs[18];
   logic [15:0] wrap_pc[3];

   initial begin
      // inputs before edge i -> expected outputs just after edge i
      vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 0, 16'h0000, 16'h0005};
      vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1, 16'h0000, 16'h000A};
      vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 2, 16'h0000, 16'h000F};
      vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 3, 16'h0000, 16'h0014};
      vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 4, 16'h0000, 16'h0014};
      vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 4, 16'h0000, 16'h0014};
      vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 3, 16'h0005, 16'h0014};
      vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 2, 16'h000A, 16'h0019};
      vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 2, 16'h000F, 16'h001E};
      vecs[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 2, 16'h0014, 16'h0023};
      vecs[10] = '{1'b1, 1'b1, 16'h0100, 1'b0, 0, 16'h0000, 16'h0100};
      vecs[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 0, 16'h0000, 16'h0105};
      vecs[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1, 16'h0100, 16'h010A};
      vecs[13] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1, 16'h0105, 16'h010F};
      vecs[14] = '{1'b1, 1'b1, 16'h0200, 1'b0, 0, 16'h0000, 16'h0200};
      vecs[15] = '{1'b1, 1'b1, 16'h0300, 1'b0, 0, 16'h0000, 16'h0300};
      vecs[16] = '{1'b1, 1'b0, 16'h0000, 1'b0, 0, 16'h0000, 16'h0305};
      vecs[17] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1, 16'h0300, 16'h030A};
      wrap_pc[0] = 16'hFFFD;
      wrap_pc[1] = 16'h0002;
      wrap_pc[2] = 16'h0007;

      reset_n  = 1'b0;
      ready    = 1'b0;
      redirect = 1'b0;
      rpc      = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.valid", insn_valid, 1'b0);
      chk("reset.count", count, 3'd0);
      chk("reset.iaddr", iaddr, 16'h0000);
      chk("reset.insn", insn, 40'h0);
      chk("reset.insn_pc", insn_pc, 16'h0000);
      chk("reset.iaddr_wrap", iaddr2, 16'hFFFD);
      model_reset();
      reset_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         ready    = vecs[i].rdy;
         redirect = vecs[i].redir;
         rpc      = vecs[i].rpc;
         step();
         $display("vec %0d valid=%0b count=%0d pc=%h iaddr=%h", i, insn_valid, count, insn_pc, iaddr);
         chk($sformatf("vec%0d.valid", i), insn_valid, vecs[i].exp_valid);
         chk($sformatf("vec%0d.count", i), count, vecs[i].exp_count);
         chk($sformatf("vec%0d.iaddr", i), iaddr, vecs[i].exp_iaddr);
         if (vecs[i].exp_valid) begin
            chk($sformatf("vec%0d.insn_pc", i), insn_pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d.insn", i), insn, rom_f(vecs[i].exp_pc));
         end
         if (i >= 1 && i <= 3) begin
            chk($sformatf("wrap%0d.valid", i), insn_valid2, 1'b1);
            chk($sformatf("wrap%0d.insn_pc", i), insn_pc2, wrap_pc[i-1]);
         end
         chk($sformatf("wrap%0d.count_le2", i), count2 <= 3'd2, 1'b1);
      end

      // Fill to full, then a single-cycle pop and refill
      redirect = 1'b0;
      ready    = 1'b0;
      repeat (5) begin
         step();
         model_check("fill");
      end
      chk("full.count", count, 3'd4);
      chk("full.iaddr", iaddr, 16'h0314);
      ready = 1'b1;
      step();
      model_check("pulse");
      chk("pulse.count", count, 3'd3);
      ready = 1'b0;
      step();
      model_check("refill_issue");
      chk("refill_issue.count", count, 3'd3);
      step();
      model_check("refill_push");
      chk("refill_push.count", count, 3'd4);

      // Asynchronous reset mid-cycle with three entries queued
      ready = 1'b1;
      step();
      chk("pre_reset.count", count, 3'd3);
      #3;
      reset_n = 1'b0;
      #1;
      chk("async_reset.count", count, 3'd0);
      chk("async_reset.valid", insn_valid, 1'b0);
      chk("async_reset.iaddr", iaddr, 16'h0000);
      chk("async_reset.insn_pc", insn_pc, 16'h0000);
      chk("async_reset.insn", insn, 40'h0);
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      for (int n = 0; n < 400; n++) begin
         ready    = ($urandom_range(0, 9) < 7);
         redirect = ($urandom_range(0, 19) == 0);
         rpc      = 16'($urandom);
         step();
         model_check($sformatf("rand%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
